// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sum stream in, block-total valid/ready stream out
// Signals:
//   in_valid / in_data            : adder sum stream (INP_DW+1 bits, cannot stall)
//   out_valid / out_ready / out_data : buffered block totals (OUT_DW bits)
//   out_drop                      : one-cycle pulse when a completed total is discarded
// Modports: master drives the sum stream and out_ready, slave is the accumulator.
interface sum_accumulator_if #(
  parameter int INP_DW = 8,
  parameter int OUT_DW = 11
);
  logic              in_valid;
  logic [INP_DW:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_DW-1:0] out_data;
  logic              out_drop;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_drop
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_drop
  );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates ACC_LEN adder sums into block totals, 2-deep output FIFO
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sum_accumulator_if.slave (in_valid/in_data in, out_valid/out_ready/out_data/out_drop)
// Build option: SUM_ACC_SAT_EN defined -> each add saturates at all-ones, else wraps.
module sum_accumulator #(
  parameter int INP_DW  = 8,
  parameter int ACC_LEN = 4,
  parameter int OUT_DW  = 11
) (
  input  logic             clk,
  input  logic             rst,
  sum_accumulator_if.slave bus
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OUT_DW-1:0] acc, acc_nxt;
  logic [OUT_DW-1:0] in_ext;
  logic [OUT_DW-1:0] sum;
  logic              total_vld;

  logic [OUT_DW-1:0] q0, q1, q0_nxt, q1_nxt;
  logic [1:0]        fcnt, fcnt_nxt;
  logic              pop, push_ok;
  logic              drop, drop_nxt;

  function automatic logic [OUT_DW-1:0] add_f(input logic [OUT_DW-1:0] a,
                                              input logic [OUT_DW-1:0] b);
`ifdef SUM_ACC_SAT_EN
    logic [OUT_DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    add_f = s[OUT_DW] ? '1 : s[OUT_DW-1:0];
`else
    add_f = a + b;
`endif
  endfunction

  assign in_ext = OUT_DW'(bus.in_data);
  assign sum    = add_f(acc, in_ext);

  // Block accumulation: the first sample of a block loads, the last one
  // produces the total instead of updating acc.
  always_comb begin
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    total_vld = 1'b0;
    if (bus.in_valid) begin
      if (cnt == '0) begin
        acc_nxt = in_ext;
        cnt_nxt = CNT_W'(1);
      end else if (cnt == CNT_LAST) begin
        total_vld = 1'b1;
        cnt_nxt   = '0;
      end else begin
        acc_nxt = sum;
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Output FIFO: q0 is always the head. A full FIFO still accepts a push
  // when the head leaves in the same cycle.
  always_comb begin
    q0_nxt   = q0;
    q1_nxt   = q1;
    fcnt_nxt = fcnt;
    pop      = (fcnt != 2'd0) && bus.out_ready;
    push_ok  = total_vld && ((fcnt != 2'd2) || pop);
    drop_nxt = total_vld && !push_ok;
    case ({pop, push_ok})
      2'b10: begin
        q0_nxt   = q1;
        fcnt_nxt = fcnt - 2'd1;
      end
      2'b01: begin
        if (fcnt == 2'd0) q0_nxt = sum;
        else              q1_nxt = sum;
        fcnt_nxt = fcnt + 2'd1;
      end
      2'b11: begin
        if (fcnt == 2'd1) begin
          q0_nxt = sum;
        end else begin
          q0_nxt = q1;
          q1_nxt = sum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      q0   <= '0;
      q1   <= '0;
      fcnt <= 2'd0;
      drop <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      acc  <= acc_nxt;
      q0   <= q0_nxt;
      q1   <= q1_nxt;
      fcnt <= fcnt_nxt;
      drop <= drop_nxt;
    end
  end

  // Head is masked so out_data reads zero whenever nothing is buffered.
  assign bus.out_valid = (fcnt != 2'd0);
  assign bus.out_data  = (fcnt != 2'd0) ? q0 : '0;
  assign bus.out_drop  = drop;

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the pipelined adder: takes the adder's `INP_DW+1`-bit sum stream, qualified by a valid bit delayed to match the adder latency, and accumulates every `ACC_LEN` valid sums into one block total. Block totals are buffered in a 2-entry output FIFO and presented on a valid/ready interface. The adder cannot stall, so a total that arrives while the FIFO is full is dropped and flagged.

## Interface
- `INP_DW`, 8: adder operand width; input sum width is `INP_DW+1`.
- `ACC_LEN`, 4: valid sums per block total; legal range ≥2.
- `OUT_DW`, 11: block total width; for a lossless total, must be ≥ `INP_DW+1+ceil(log2(ACC_LEN))`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a valid sum this cycle.
- `in_data`  in  `INP_DW+1`  unsigned adder output.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts head this cycle.
- `out_data`  out  `OUT_DW`  FIFO head block total; 0 when FIFO empty.
- `out_drop`  out  1  one-cycle pulse: a completed total was discarded.

## Operation
- Sample counter `cnt`, 0..`ACC_LEN-1`; accumulator `acc`, `OUT_DW` bits, unsigned.
- `in_valid=0`: `cnt` and `acc` hold.
- `in_valid=1`, `cnt=0`: `acc <= in_data` (zero-extended); `cnt <= 1`.
- `in_valid=1`, `0<cnt<ACC_LEN-1`: `acc <= acc+in_data`; `cnt <= cnt+1`.
- `in_valid=1`, `cnt=ACC_LEN-1`: total `T = acc+in_data` is pushed; `cnt <= 0`. `acc` is don't-care, and is overwritten on the next sample.
- Arithmetic: modulo 2^`OUT_DW` (wrap), unless the `_EN` macro is defined (see Configuration).
- FIFO: depth 2, in order.
  - Pop when `out_valid && out_ready`.
  - Push of `T` succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise `T` is discarded, FIFO contents are unchanged, and `out_drop=1` on the next cycle.
- `out_ready` while `out_valid=0`: no effect.
- `out_data` and `out_valid` are stable while `out_valid=1 && out_ready=0`.

## Timing
- Reset values:
  - `cnt=0`, `acc=0`, FIFO empty.
  - `out_valid=0`, `out_data=0`, `out_drop=0`.
- Reset mid-block discards the partial accumulation and all buffered totals. The first valid sample after reset starts a new block.
- Latency: final sample of a block at edge t, FIFO empty → `out_valid=1` with `T` after edge t (visible cycle t+1).
- Throughput: one sample per cycle sustained. One total per `ACC_LEN` cycles when `out_ready` is held high.
- Full plus simultaneous push and pop: head leaves, `T` enters the tail, no drop.
- Empty plus push: `T` becomes head next cycle. Same-cycle bypass to output is not allowed.
- `out_drop` is registered and pulses for exactly one cycle per discarded total.

## Configuration
- `SUM_ACC_SAT_EN` defined: each add saturates at 2^`OUT_DW`-1. A saturated total is pushed as all-ones.
- `SUM_ACC_SAT_EN` undefined: each add wraps modulo 2^`OUT_DW`.
- Both builds are identical when `OUT_DW` meets the lossless bound.

## Test plan
- **Basic block:** `ACC_LEN=4`, `out_ready=1`, sums 10, 20, 30, 40 on consecutive cycles → one `out_valid` pulse with `out_data=100`, one cycle after the 40.
- **Gapped input:** same sums with `in_valid` low on alternate cycles → `out_data=100`; `cnt` holds across gaps.
- **Backpressure and drop:** `out_ready=0`, three blocks of 1+1+1+1 → FIFO holds 4, 4 with `out_valid=1`; third total dropped with a single `out_drop` pulse. Then `out_ready=1` → exactly two pops of 4.
- **Full with simultaneous push and pop:** FIFO full of totals 4 and 8; final sample of a block of 3+3+3+3 arrives on the same cycle as `out_ready=1` → no drop. Later pops return 8 then 12.
- **Overflow:** `INP_DW=8`, `OUT_DW=9`, sums 511 ×4 → wrap build `out_data=(4*511) mod 512=508`; `SUM_ACC_SAT_EN` build `out_data=511`.
- **Reset mid-operation:** assert `rst` after 2 samples of 5 with 1 total buffered → `out_valid=0` next cycle. The next 4 samples of 5 give `out_data=20`.
